// File: rtl/sw_bcast_rx_if.sv
// rtl/sw_bcast_rx_if.sv - broadcast offer and data_mem write-port bundle for sw_bcast_rx
// The parent core side is master; the buffer is slave.
interface sw_bcast_rx_if #(
  parameter int AW = 10
);
  logic          bcast_valid;
  logic [AW-1:0] bcast_addr;
  logic [31:0]   bcast_data;
  logic          bcast_ready;
  logic          drain_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;

  modport master (
    output bcast_valid, bcast_addr, bcast_data, drain_en,
    input  bcast_ready, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  bcast_valid, bcast_addr, bcast_data, drain_en,
    output bcast_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sw_bcast_rx.sv
// rtl/sw_bcast_rx.sv - pending-broadcast store buffer draining into local data_mem
// Coalesces same-address back-to-back stores and forwards pending data to local loads.
module sw_bcast_rx #(
  parameter int DEPTH          = 4,
  parameter int DATA_MEM_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  sw_bcast_rx_if.slave              bus,
  input  logic [DATA_MEM_WIDTH-1:0] lw_addr,
  output logic                      lw_hit,
  output logic [31:0]               lw_data,
  output logic                      empty,
  output logic                      overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_MEM_WIDTH-1:0] addr_q [DEPTH];
  logic [31:0]               data_q [DEPTH];
  logic [PW-1:0]             head;
  logic [PW-1:0]             tail;
  logic [PW-1:0]             tail_prev;
  logic [CW-1:0]             count;
  logic                      drain;
  logic                      full;
  logic                      coalesce;
  logic                      accept;
  logic                      enq;

  always_comb begin
    tail_prev = tail - PW'(1);
    drain     = (count != '0) && bus.drain_en;
    full      = (count == CW'(DEPTH));
    // The youngest entry may only absorb new data if it is not leaving this cycle.
    coalesce  = bus.bcast_valid && (count != '0) &&
                (addr_q[tail_prev] == bus.bcast_addr) &&
                !(drain && (tail_prev == head));
    bus.bcast_ready = !full || drain || coalesce;
    accept    = bus.bcast_valid && bus.bcast_ready;
    enq       = accept && !coalesce;
  end

  assign bus.mem_we   = drain;
  assign bus.mem_addr = addr_q[head];
  assign bus.mem_din  = data_q[head];
  assign empty        = (count == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drain) head <= head + PW'(1);
      if (enq)   tail <= tail + PW'(1);
      count <= count + CW'(enq) - CW'(drain);
      if (bus.bcast_valid && !bus.bcast_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (enq) begin
        addr_q[tail] <= bus.bcast_addr;
        data_q[tail] <= bus.bcast_data;
      end else if (accept && coalesce) begin
        data_q[tail_prev] <= bus.bcast_data;
      end
    end
  end

  // Oldest to youngest, so the last match left standing is the youngest.
  always_comb begin
    lw_hit  = 1'b0;
    lw_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (addr_q[head + PW'(i)] == lw_addr)) begin
        lw_hit  = 1'b1;
        lw_data = data_q[head + PW'(i)];
      end
    end
  end
endmodule

// File: tb/tb_sw_bcast_rx.sv
// tb/tb_sw_bcast_rx.sv - self-checking bench for sw_bcast_rx
// Expected data_mem writes are queued as stimulus is driven and popped by a write monitor.
module tb_sw_bcast_rx;
  localparam int AW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] lw_addr = '0;
  logic          lw_hit;
  logic [31:0]   lw_data;
  logic          empty;
  logic          overflow;
  int            tests_run = 0;
  int            tests_failed = 0;
  wr_t           exp_q[$];
  wr_t           mon_e;

  always #5 clk = ~clk;

  sw_bcast_rx_if #(.AW(AW)) bus ();

  sw_bcast_rx #(.DEPTH(4), .DATA_MEM_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .lw_addr  (lw_addr),
    .lw_hit   (lw_hit),
    .lw_data  (lw_data),
    .empty    (empty),
    .overflow (overflow)
  );

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL mem_write: got addr %h data %h, required no write", bus.mem_addr, bus.mem_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_din} !== mon_e) begin
          tests_failed++;
          $display("FAIL mem_write: got addr %h data %h, required addr %h data %h",
                   bus.mem_addr, bus.mem_din, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [31:0] d, input logic de);
    bus.bcast_valid = v;
    bus.bcast_addr  = a;
    bus.bcast_data  = d;
    bus.drain_en    = de;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    cyc();
    cyc();
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b, required 1", empty); end
    tests_run++; if (bus.bcast_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b, required 1", bus.bcast_ready); end
    tests_run++; if (bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b, required 0", bus.mem_we); end
    tests_run++; if (lw_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_lw_hit: got %b, required 0", lw_hit); end
    tests_run++; if (lw_data !== 32'd0) begin tests_failed++; $display("FAIL reset_lw_data: got %h, required 0", lw_data); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    cyc();
  endtask

  task automatic test_order();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(8'h10 + i), 32'(i + 1), 1'b0);
      exp_q.push_back({AW'(8'h10 + i), 32'(i + 1)});
      cyc();
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL order_empty: got %b, required 1", empty); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL order_writes: got %0d missing, required 0", exp_q.size()); end
    cyc();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(8'h21 + i), 32'(32'h100 + i), 1'b0);
      exp_q.push_back({AW'(8'h21 + i), 32'(32'h100 + i)});
      cyc();
    end
    drive(1'b1, 8'h20, 32'hAA, 1'b0);
    @(negedge clk);
    tests_run++; if (bus.bcast_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready: got %b, required 0", bus.bcast_ready); end
    cyc();
    drive(1'b1, 8'h20, 32'hAA, 1'b1);
    exp_q.push_back({8'h20, 32'hAA});
    @(negedge clk);
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow_set: got %b, required 1", overflow); end
    tests_run++; if (bus.bcast_ready !== 1'b1) begin tests_failed++; $display("FAIL full_drain_ready: got %b, required 1", bus.bcast_ready); end
    cyc();
    drive(1'b1, 8'h25, 32'hCC, 1'b0);
    @(negedge clk);
    tests_run++; if (bus.bcast_ready !== 1'b0) begin tests_failed++; $display("FAIL still_full_ready: got %b, required 0", bus.bcast_ready); end
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    repeat (4) cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL overflow_drain_empty: got %b, required 1", empty); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL overflow_sticky: got %b, required 1", overflow); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL overflow_writes: got %0d missing, required 0", exp_q.size()); end
    cyc();
  endtask

  task automatic test_coalesce();
    drive(1'b1, 8'h30, 32'd5, 1'b0);
    cyc();
    drive(1'b1, 8'h30, 32'd6, 1'b0);
    exp_q.push_back({8'h30, 32'd6});
    @(negedge clk);
    tests_run++; if (bus.bcast_ready !== 1'b1) begin tests_failed++; $display("FAIL coalesce_ready: got %b, required 1", bus.bcast_ready); end
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL coalesce_count1: got empty %b, required 1", empty); end
    cyc();
    // Coalescing into a full buffer must still be accepted.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(8'h3C + i), 32'(32'h200 + i), 1'b0);
      if (i < 3) exp_q.push_back({AW'(8'h3C + i), 32'(32'h200 + i)});
      cyc();
    end
    drive(1'b1, 8'h3F, 32'h77, 1'b0);
    exp_q.push_back({8'h3F, 32'h77});
    @(negedge clk);
    tests_run++; if (bus.bcast_ready !== 1'b1) begin tests_failed++; $display("FAIL full_coalesce_ready: got %b, required 1", bus.bcast_ready); end
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    repeat (4) cyc();
    // Same address as a single draining head: must enqueue, not coalesce.
    drive(1'b1, 8'h38, 32'd1, 1'b0);
    exp_q.push_back({8'h38, 32'd1});
    cyc();
    drive(1'b1, 8'h38, 32'd2, 1'b1);
    exp_q.push_back({8'h38, 32'd2});
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL coalesce_drain_empty: got %b, required 1", empty); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL coalesce_writes: got %0d missing, required 0", exp_q.size()); end
    cyc();
  endtask

  task automatic test_forward();
    drive(1'b1, 8'h40, 32'd7, 1'b0); exp_q.push_back({8'h40, 32'd7}); cyc();
    drive(1'b1, 8'h41, 32'd8, 1'b0); exp_q.push_back({8'h41, 32'd8}); cyc();
    drive(1'b1, 8'h40, 32'd9, 1'b0); exp_q.push_back({8'h40, 32'd9}); cyc();
    drive(1'b0, '0, '0, 1'b0);
    lw_addr = 8'h40;
    @(negedge clk);
    tests_run++; if ({lw_hit, lw_data} !== {1'b1, 32'd9}) begin tests_failed++; $display("FAIL fwd_youngest: got hit %b data %h, required hit 1 data 9", lw_hit, lw_data); end
    cyc();
    lw_addr = 8'h42;
    @(negedge clk);
    tests_run++; if ({lw_hit, lw_data} !== {1'b0, 32'd0}) begin tests_failed++; $display("FAIL fwd_miss: got hit %b data %h, required hit 0 data 0", lw_hit, lw_data); end
    cyc();
    lw_addr = 8'h41;
    @(negedge clk);
    tests_run++; if ({lw_hit, lw_data} !== {1'b1, 32'd8}) begin tests_failed++; $display("FAIL fwd_middle: got hit %b data %h, required hit 1 data 8", lw_hit, lw_data); end
    cyc();
    lw_addr = 8'h40;
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    tests_run++; if ({lw_hit, lw_data} !== {1'b1, 32'd9}) begin tests_failed++; $display("FAIL fwd_while_drain: got hit %b data %h, required hit 1 data 9", lw_hit, lw_data); end
    cyc();
    repeat (2) cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++; if (lw_hit !== 1'b0) begin tests_failed++; $display("FAIL fwd_after_drain: got %b, required 0", lw_hit); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL fwd_writes: got %0d missing, required 0", exp_q.size()); end
    cyc();
  endtask

  task automatic test_same_cycle();
    lw_addr = 8'h50;
    drive(1'b1, 8'h50, 32'd1, 1'b0);
    exp_q.push_back({8'h50, 32'd1});
    @(negedge clk);
    tests_run++; if (lw_hit !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_hit: got %b, required 0", lw_hit); end
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++; if ({lw_hit, lw_data} !== {1'b1, 32'd1}) begin tests_failed++; $display("FAIL next_cycle_hit: got hit %b data %h, required hit 1 data 1", lw_hit, lw_data); end
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL same_cycle_writes: got %0d missing, required 0", exp_q.size()); end
    cyc();
  endtask

  task automatic test_reset_mid();
    lw_addr = '0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(8'h60 + i), 32'(i + 1), 1'b0);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tests_run++; if ({overflow, empty} !== 2'b10) begin tests_failed++; $display("FAIL pre_reset: got overflow %b empty %b, required 1 0", overflow, empty); end
    cyc();
    reset = 1'b0;
    drive(1'b1, 8'h63, 32'd9, 1'b1);
    exp_q.push_back({8'h60, 32'd1});
    @(negedge clk);
    tests_run++; if (bus.mem_we !== 1'b1) begin tests_failed++; $display("FAIL reset_cycle_we: got %b, required 1", bus.mem_we); end
    cyc();
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_empty: got %b, required 1", empty); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_overflow: got %b, required 0", overflow); end
    tests_run++; if (bus.mem_we !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_we: got %b, required 0", bus.mem_we); end
    tests_run++; if (bus.bcast_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_ready: got %b, required 1", bus.bcast_ready); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL mid_reset_writes: got %0d missing, required 0", exp_q.size()); end
    cyc();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, '0, '0, 1'b0);
    test_reset();
    test_order();
    test_overflow();
    test_coalesce();
    test_forward();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sw_bcast_rx.md
SW_BCAST_RX -- requirements
Module: sw_bcast_rx

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-broadcast buffer entries (power of two, >=2).
REQ-002 Parameter DATA_MEM_WIDTH, default from common.vh, data-memory address width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low reset (reset==0 clears state at the next posedge).
REQ-005 bcast_valid  input  1  parent core offers one committed store this cycle.
REQ-006 bcast_addr  input  DATA_MEM_WIDTH  store address of offered broadcast.
REQ-007 bcast_data  input  32  store data of offered broadcast.
REQ-008 bcast_ready  output  1  buffer accepts the offered broadcast this cycle.
REQ-009 drain_en  input  1  local data_mem write port A is free this cycle.
REQ-010 mem_we  output  1  write strobe to data_mem port A.
REQ-011 mem_addr  output  DATA_MEM_WIDTH  write address to data_mem port A.
REQ-012 mem_din  output  32  write data to data_mem port A.
REQ-013 lw_addr  input  DATA_MEM_WIDTH  address of the local load being resolved.
REQ-014 lw_hit  output  1  a pending buffered broadcast matches lw_addr.
REQ-015 lw_data  output  32  data of the youngest matching pending entry; 0 when lw_hit==0.
REQ-016 empty  output  1  no pending entries.
REQ-017 overflow  output  1  sticky: a broadcast was offered while bcast_ready==0.

Function
REQ-018 Buffer SHALL be a circular FIFO with head pointer, tail pointer and count (0..DEPTH, width $clog2(DEPTH)+1); pointers wrap modulo DEPTH.
REQ-019 drain SHALL be count!=0 && drain_en; mem_we==drain, mem_addr/mem_din SHALL be head entry, combinational, zero-latency; head advances and count decrements at the posedge.
REQ-020 bcast_ready SHALL be count<DEPTH || drain (full buffer accepts when the head drains the same cycle).
REQ-021 Enqueue SHALL occur on bcast_valid && bcast_ready, writing addr/data at tail; tail advances and count increments at the posedge.
REQ-022 Coalesce: if enqueue fires, count!=0, bcast_addr equals the tail-1 entry address, and that entry is not the head being drained this cycle, data SHALL overwrite that entry; tail and count unchanged.
REQ-023 Simultaneous enqueue (non-coalesced) and drain SHALL leave count unchanged.
REQ-024 Coalescing SHALL be evaluated before readiness: a coalescing broadcast is accepted even when count==DEPTH, i.e. bcast_ready includes this case.
REQ-025 lw_hit/lw_data SHALL search only entries valid at cycle start, youngest first; an entry draining this cycle still participates; a broadcast arriving this cycle SHALL NOT be forwarded until the next cycle.
REQ-026 bcast_valid && !bcast_ready SHALL drop the broadcast and set overflow, held until reset.
REQ-027 empty SHALL equal count==0.
REQ-028 Stores SHALL reach data_mem in exactly parent commit order, except for coalesced same-address consecutive stores, where only the last data is written.

Reset
REQ-029 On reset==0 at posedge: count, head, tail SHALL be 0 and overflow 0; entry contents need not be cleared.
REQ-030 Outputs after reset: mem_we=0, lw_hit=0, lw_data=0, empty=1, bcast_ready=1, overflow=0; mem_addr/mem_din don't-care.
REQ-031 Reset asserted during simultaneous enqueue/drain SHALL take priority; the pending write for that cycle still appears on mem_we combinationally but no pointer moves.

Verification
REQ-032 Enqueue addr 0x10/0x11/0x12 data 1/2/3 with drain_en=0, then drain_en=1 for 3 cycles -> mem_we writes (0x10,1),(0x11,2),(0x12,3) in order; empty=1 afterwards.
REQ-033 Fill to DEPTH=4 with drain_en=0, offer addr 0x20 -> bcast_ready=0, overflow=1 sticky; same offer with drain_en=1 -> accepted, count stays 4.
REQ-034 Enqueue (0x30,5) then (0x30,6) back-to-back with drain_en=0 -> count=1; drain writes (0x30,6) once.
REQ-035 Pending (0x40,7) then (0x41,8) then (0x40,9) non-adjacent; lw_addr=0x40 -> lw_hit=1, lw_data=9; lw_addr=0x42 -> lw_hit=0, lw_data=0.
REQ-036 Offer (0x50,1) and lw_addr=0x50 in same cycle from empty -> lw_hit=0 that cycle, lw_hit=1, lw_data=1 next cycle.
REQ-037 With 3 entries pending and overflow=1, drive reset=0 one cycle -> empty=1, overflow=0, mem_we=0, bcast_ready=1 next cycle.
